fetch_ifid_stage: RTL and testbench
===================================

# fetch_ifid_stage

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined processor. It owns the PC and drives instruction-memory requests. It absorbs memory wait cycles and hazard stalls, and applies branch/jump redirects from downstream. Its IF/ID outputs feed the decode-stage control decoder: opcode = `id_instr[15:11]`, last_bits = `id_instr[1:0]`, plus `id_HALT`.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, 16'h0800: bubble instruction (opcode 00001).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_addr` out 16: fetch address; always equals `pc`.
- `imem_req` out 1: fetch request. High in FETCH, low in HOLD/HALTED.
- `imem_rdata` in 16: instruction word.
- `imem_done` in 1: `imem_rdata` is valid for the `imem_addr` presented this cycle. Memory treats each cycle's address as a fresh request.
- `stall` in 1: hazard unit holds IF/ID.
- `redirect` in 1: taken branch/jump/JR resolved downstream.
- `redirect_pc` in 16: redirect target.
- `id_instr` out 16: IF/ID instruction.
- `id_pc_plus2` out 16: PC+2 of `id_instr`.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_HALT` out 1: `id_valid & (id_instr[15:11]==5'b00000)`.
- `err` out 1: sticky misaligned-redirect flag.

## Operation
- Registers:
  - `pc` (16)
  - `state` ∈ {FETCH, HOLD, HALTED}
  - skid buffer `buf_instr` (16)
  - IF/ID: `id_instr`, `id_pc_plus2`, `id_valid`
  - `err`
- Reset (asynchronous, `rst`=0): `pc`=RESET_PC, `state`=FETCH, `id_instr`=NOP_INSTR, `id_pc_plus2`=0, `id_valid`=0, `buf_instr`=NOP_INSTR, `err`=0. Resulting outputs: `imem_req`=1, `imem_addr`=RESET_PC, `id_HALT`=0.
- Priority per cycle: redirect > stall > fetch.
- Redirect (any state):
  - `pc` ← {redirect_pc[15:1],1'b0}.
  - IF/ID ← {NOP_INSTR, 0, valid=0}.
  - Skid buffer discarded.
  - `state` ← FETCH.
  - Any same-cycle `imem_done` data is dropped.
  - Overrides `stall`.
  - Exits HALTED, since a halt fetched on a wrong path is squashed.
  - `err` ← `err | redirect_pc[0]`.
- FETCH, no redirect:
  - `imem_done`=1, `stall`=0: IF/ID ← {imem_rdata, pc+2, 1}; `pc` ← pc+2. If `imem_rdata[15:11]`==00000, `state` ← HALTED, else stay FETCH.
  - `imem_done`=1, `stall`=1: `buf_instr` ← imem_rdata; IF/ID unchanged; `pc` unchanged; `state` ← HOLD.
  - `imem_done`=0, `stall`=0: IF/ID ← bubble (NOP_INSTR, pc+2 field unchanged, valid=0).
  - `imem_done`=0, `stall`=1: IF/ID unchanged.
- HOLD, no redirect:
  - `stall`=1: everything holds.
  - `stall`=0: IF/ID ← {buf_instr, pc+2, 1}; `pc` ← pc+2; `state` ← HALTED if `buf_instr` is HALT, else FETCH.
- HALTED, no redirect:
  - `pc` frozen; no requests.
  - `stall`=0: IF/ID ← bubble.
  - `stall`=1: IF/ID holds, so the HALT stays visible on `id_HALT`.
- Arithmetic: pc+2 is modulo 2^16 (16'hFFFE+2 = 16'h0000); PC bit 0 is always 0.
- `stall` with `id_valid`=0 is legal and simply holds the bubble.

## Timing
- `imem_addr`/`imem_req` are registered-state decodes; no combinational path from `imem_rdata`, `stall` or `redirect` to `imem_addr`.
- `id_*` outputs are registers, except `id_HALT`, which is a decode of registered IF/ID.
- Throughput: 1 instruction/cycle with `imem_done` tied high and no stall.
- Fetch latency: address at cycle n with `imem_done`=1 → `id_instr` valid after edge n+1.
- Redirect asserted in cycle n → `imem_addr`=target in cycle n+1 → target instruction in IF/ID after edge n+2 (1 bubble).
- Stall release from HOLD: buffered instruction enters IF/ID on the first edge with `stall`=0; the next fetch request starts the following cycle.
- Reset deassertion: first request issues in the first cycle after `rst` rises; no extra cycle of delay.
- Reset mid-stall or mid-HOLD: all state clears immediately and the buffered word is lost.

## Test plan
- **Reset/stream.** Assert `rst`=0 with RESET_PC=0, `imem_done`=1, memory words 0x4001, 0x4002, 0x4003, then release. Required: `imem_addr` = 0, 2, 4 on consecutive cycles; `id_instr` = 0x4001 with `id_pc_plus2`=2, then 0x4002 with 4; `id_valid`=1 from the first edge.
- **Wait states.** Hold `imem_done`=0 for 2 cycles at pc=4. Required: two bubbles (id_instr=0x0800, valid=0); pc stays 4; then the word at 4 loads.
- **Stall into HOLD.** Assert `stall` in the same cycle as `imem_done` at pc=6 and keep it 3 cycles. Required: `imem_req`=0 during HOLD, IF/ID unchanged; on release, the word from address 6 loads with `id_pc_plus2`=8 and `imem_addr`=8 the next cycle.
- **Redirect over stall.** Assert `redirect`=1, `redirect_pc`=0x0100, `stall`=1 while in HOLD. Required: bubble in IF/ID, `imem_addr`=0x0100 next cycle, buffered word never appears.
- **Halt and squash.** Fetch 0x0000 at pc=0x20. Required: `id_HALT`=1, `imem_req`=0, pc frozen at 0x22, bubbles follow. Then `redirect_pc`=0x0040 resumes fetch at 0x0040 and `id_HALT` returns to 0.
- **Wrap and error.** Start at pc=16'hFFFE. Required: next `imem_addr`=0x0000. Then `redirect_pc`=0x0013. Required: `imem_addr`=0x0012, `err`=1, and `err` stays 1 until reset.

Source files
------------

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit pipeline.
// Owns the PC, issues imem requests, absorbs wait/stall cycles and applies redirects.
module fetch_ifid_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   output logic        imem_req,
   input  logic [15:0] imem_rdata,
   input  logic        imem_done,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] id_instr,
   output logic [15:0] id_pc_plus2,
   output logic        id_valid,
   output logic        id_HALT,
   output logic        err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_HOLD   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_buf_instr;
   logic [15:0] r_id_instr;
   logic [15:0] r_id_pc_plus2;
   logic        r_id_valid;
   logic        r_err;

   logic [15:0] w_pc_plus2;
   logic        w_rdata_is_halt;
   logic        w_buf_is_halt;

   assign w_pc_plus2      = r_pc + 16'd2;
   assign w_rdata_is_halt = (imem_rdata[15:11] == 5'b00000);
   assign w_buf_is_halt   = (r_buf_instr[15:11] == 5'b00000);

   // Memory handshake: imem_req/imem_addr come only from registered state; a word
   // is consumed on any edge where imem_req and imem_done are both high, and an
   // address that was not accepted is simply presented again the next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_buf_instr   <= NOP_INSTR;
         r_id_instr    <= NOP_INSTR;
         r_id_pc_plus2 <= 16'h0000;
         r_id_valid    <= 1'b0;
         r_err         <= 1'b0;
      end else if (redirect) begin
         // Wrong-path work (buffered word, same-cycle data, a fetched HALT) is squashed.
         r_state       <= S_FETCH;
         r_pc          <= {redirect_pc[15:1], 1'b0};
         r_buf_instr   <= NOP_INSTR;
         r_id_instr    <= NOP_INSTR;
         r_id_pc_plus2 <= 16'h0000;
         r_id_valid    <= 1'b0;
         r_err         <= r_err | redirect_pc[0];
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_done) begin
                  if (stall) begin
                     r_buf_instr <= imem_rdata;
                     r_state     <= S_HOLD;
                  end else begin
                     r_id_instr    <= imem_rdata;
                     r_id_pc_plus2 <= w_pc_plus2;
                     r_id_valid    <= 1'b1;
                     r_pc          <= w_pc_plus2;
                     r_state       <= w_rdata_is_halt ? S_HALTED : S_FETCH;
                  end
               end else if (!stall) begin
                  r_id_instr <= NOP_INSTR;
                  r_id_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               // PC still addresses the buffered word until it enters IF/ID.
               if (!stall) begin
                  r_id_instr    <= r_buf_instr;
                  r_id_pc_plus2 <= w_pc_plus2;
                  r_id_valid    <= 1'b1;
                  r_pc          <= w_pc_plus2;
                  r_state       <= w_buf_is_halt ? S_HALTED : S_FETCH;
               end
            end
            S_HALTED: begin
               if (!stall) begin
                  r_id_instr <= NOP_INSTR;
                  r_id_valid <= 1'b0;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign imem_req    = (r_state == S_FETCH);
   assign id_instr    = r_id_instr;
   assign id_pc_plus2 = r_id_pc_plus2;
   assign id_valid    = r_id_valid;
   assign id_HALT     = r_id_valid & (r_id_instr[15:11] == 5'b00000);
   assign err         = r_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed vector table, reset corner case and a
// scoreboarded random stream with memory wait states.
module tb_fetch_ifid_stage;

   logic        clk;
   logic        rst;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic [15:0] imem_rdata;
   logic        imem_done;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] id_instr;
   logic [15:0] id_pc_plus2;
   logic        id_valid;
   logic        id_HALT;
   logic        err;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic        done;
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic [15:0] rdata;
      logic [15:0] addr;
      logic        req;
      logic [15:0] instr;
      logic [15:0] pc2;
      logic        valid;
      logic        halt;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   fetch_ifid_stage dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_rdata (imem_rdata),
      .imem_done  (imem_done),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .id_instr   (id_instr),
      .id_pc_plus2(id_pc_plus2),
      .id_valid   (id_valid),
      .id_HALT    (id_HALT),
      .err        (err),
      .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic d, logic s, logic r, logic [15:0] rpc, logic [15:0] rd,
                              logic [15:0] a, logic rq, logic [15:0] ins, logic [15:0] p2,
                              logic v, logic h, logic e);
    vec_t t;
    t.done = d; t.stall = s; t.redir = r; t.rpc = rpc; t.rdata = rd;
    t.addr = a; t.req = rq; t.instr = ins; t.pc2 = p2; t.valid = v; t.halt = h; t.err = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic s, input logic r, input logic [15:0] rpc,
                       input logic [15:0] rd);
    imem_done   = d;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_rdata  = rd;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] a, input logic rq,
                            input logic [15:0] ins, input logic [15:0] p2, input logic v,
                            input logic h, input logic e);
    chk({tag, " addr"},  imem_addr, a);
    chk({tag, " req"},   {15'd0, imem_req}, {15'd0, rq});
    chk({tag, " instr"}, id_instr, ins);
    chk({tag, " pc2"},   id_pc_plus2, p2);
    chk({tag, " valid"}, {15'd0, id_valid}, {15'd0, v});
    chk({tag, " halt"},  {15'd0, id_HALT}, {15'd0, h});
    chk({tag, " err"},   {15'd0, err}, {15'd0, e});
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] word;
    logic        d;
    logic [31:0] got;

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    //        done stall redir rpc      rdata    | addr     req instr    pc2      v  h  e
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4001, 16'h0002, 1, 16'h4001, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4002, 16'h0004, 1, 16'h4002, 16'h0004, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hDEAD, 16'h0004, 1, 16'h0800, 16'h0004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hDEAD, 16'h0004, 1, 16'h0800, 16'h0004, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4003, 16'h0006, 1, 16'h4003, 16'h0006, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h4004, 16'h0006, 0, 16'h4003, 16'h0006, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hBEEF, 16'h0006, 0, 16'h4003, 16'h0006, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 16'hBEEF, 16'h0006, 0, 16'h4003, 16'h0006, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'hBEEF, 16'h0008, 1, 16'h4004, 16'h0008, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h4005, 16'h0008, 0, 16'h4004, 16'h0008, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0100, 16'h0000, 16'h0100, 1, 16'h0800, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4006, 16'h0102, 1, 16'h4006, 16'h0102, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0020, 16'h4007, 16'h0020, 1, 16'h0800, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0022, 0, 16'h0000, 16'h0022, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h4008, 16'h0022, 0, 16'h0000, 16'h0022, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4008, 16'h0022, 0, 16'h0800, 16'h0022, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0040, 16'h0000, 16'h0040, 1, 16'h0800, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4009, 16'h0042, 1, 16'h4009, 16'h0042, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 1, 16'h0800, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h400A, 16'h0000, 1, 16'h400A, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0013, 16'h0000, 16'h0012, 1, 16'h0800, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h400B, 16'h0014, 1, 16'h400B, 16'h0014, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0040, 16'h0000, 16'h0040, 1, 16'h0800, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h400C, 16'h0042, 1, 16'h400C, 16'h0042, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 16'h0042, 0, 16'h400C, 16'h0042, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h4444, 16'h0044, 0, 16'h0000, 16'h0044, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h4444, 16'h0044, 0, 16'h0800, 16'h0044, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0050, 16'h0000, 16'h0050, 1, 16'h0800, 16'h0000, 0, 0, 1));

    // reset state, checked while reset is still held
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 16'h0000, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("reset state", {14'd0, dbg_state}, 16'h0000);

    // release in the low phase so the first request is serviced on the next edge
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].done, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].rdata);
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].addr, vecs[i].req, vecs[i].instr,
                 vecs[i].pc2, vecs[i].valid, vecs[i].halt, vecs[i].err);
    end

    // reset in the middle of HOLD drops the buffered word and the error flag
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h4AAA);
    @(posedge clk);
    #1;
    chk("hold entry req", {15'd0, imem_req}, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async rst", 16'h0000, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4111);
    @(posedge clk);
    #1;
    check_outs("post rst", 16'h0002, 1'b1, 16'h4111, 16'h0002, 1'b1, 1'b0, 1'b0);

    // scoreboarded stream with random wait states
    exp_pc = 16'h0002;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk($sformatf("s%0d addr", c), imem_addr, exp_pc);
      chk($sformatf("s%0d req", c), {15'd0, imem_req}, 16'h0001);
      d    = 1'($urandom_range(0, 3) != 0);
      word = {5'($urandom_range(1, 31)), 11'($urandom_range(0, 2047))};
      drive(d, 1'b0, 1'b0, 16'h0000, word);
      if (d) begin
        exp_q.push_back({word, exp_pc + 16'd2});
        exp_pc = exp_pc + 16'd2;
      end
      @(posedge clk);
      #1;
      if (id_valid) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("s%0d unexpected", c), {15'd0, id_valid}, 16'h0000);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("s%0d instr", c), id_instr, got[31:16]);
          chk($sformatf("s%0d pc2", c), id_pc_plus2, got[15:0]);
        end
      end else begin
        chk($sformatf("s%0d bubble", c), id_instr, 16'h0800);
      end
    end
    chk("stream leftover", 16'(exp_q.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
